// File: rtl/rr_mux_arbiter.sv
`default_nettype none
//==============================================================================
// rr_mux_arbiter : round-robin owner/hold arbiter driving a shared mux select.
// Optional macro ARB_TIMEOUT_EN adds a forced-release hold timer.  Rev 1.0
//==============================================================================
module rr_mux_arbiter #(
  parameter int p_sel_width = 2,
  parameter int p_timeout   = 16
) (
  input  logic                          i_w_clk,
  input  logic                          i_w_rst_n,
  input  logic [(1<<p_sel_width)-1:0]   i_w_req,
  input  logic                          i_w_done,
  output logic [(1<<p_sel_width)-1:0]   o_w_grant,
  output logic [p_sel_width-1:0]        o_w_sel,
  output logic                          o_w_valid,
  output logic                          o_w_timeout
);

  localparam int       c_num_req  = 1 << p_sel_width;
  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_hold = 1'b1;

  logic [0:0]             r_state;
  logic [p_sel_width-1:0] r_last;
  logic [p_sel_width-1:0] r_sel;
  logic [c_num_req-1:0]   r_grant;
  logic                   r_valid;

  logic [p_sel_width-1:0] w_base;
  logic [c_num_req-1:0]   w_req_masked;
  logic [p_sel_width-1:0] w_winner;
  logic                   w_found;
  logic                   w_norm_rel;
  logic                   w_force;
  logic                   w_release;

  // While holding, the search starts after the owner and excludes it, so a
  // releasing owner can only win again after an idle cycle.
  always_comb begin
    w_base       = (r_state == c_st_hold) ? r_sel : r_last;
    w_req_masked = i_w_req;
    if (r_state == c_st_hold) begin
      w_req_masked[r_sel] = 1'b0;
    end
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < c_num_req; i++) begin
      if (!w_found && w_req_masked[w_base + p_sel_width'(i + 1)]) begin
        w_found  = 1'b1;
        w_winner = w_base + p_sel_width'(i + 1);
      end
    end
  end

  assign w_norm_rel = i_w_done || !i_w_req[r_sel];
  assign w_release  = (r_state == c_st_hold) && (w_norm_rel || w_force);

  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n) begin
      r_state <= c_st_idle;
      r_last  <= p_sel_width'(c_num_req - 1);
      r_sel   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_found) begin
            r_state <= c_st_hold;
            r_sel   <= w_winner;
            r_grant <= {{(c_num_req-1){1'b0}}, 1'b1} << w_winner;
            r_valid <= 1'b1;
          end
        end
        default: begin
          if (w_release) begin
            r_last <= r_sel;
            if (w_found) begin
              r_sel   <= w_winner;
              r_grant <= {{(c_num_req-1){1'b0}}, 1'b1} << w_winner;
            end else begin
              r_state <= c_st_idle;
              r_grant <= '0;
              r_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(p_timeout) + 1;

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_timeout;
  logic               w_new_grant;

  assign w_new_grant = w_found && ((r_state == c_st_idle) || w_release);
  // Counter reads p_timeout-1 during the owner's p_timeout-th held cycle.
  assign w_force     = (r_state == c_st_hold) && (r_cnt == c_cnt_w'(p_timeout - 1));

  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_release && w_force && !w_norm_rel;
      if (w_new_grant) begin
        r_cnt <= '0;
      end else if (r_state == c_st_hold) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign o_w_timeout = r_timeout;
`else
  assign w_force     = 1'b0;
  assign o_w_timeout = 1'b0;
`endif

  assign o_w_grant = r_grant;
  assign o_w_sel   = r_sel;
  assign o_w_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
//==============================================================================
// tb_rr_mux_arbiter : directed + random checks against a behavioural model.
// Rev 1.0
//==============================================================================
module tb_rr_mux_arbiter;

  localparam int SELW = 2;
  localparam int NREQ = 4;
  localparam int TMO  = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] grant;
  logic [SELW-1:0] sel;
  logic            valid;
  logic            timeout;

  logic [NREQ-1:0] din [NREQ];
  logic [NREQ-1:0] mux_out;

  int compared   = 0;
  int mismatched = 0;

  // behavioural model state
  int m_owner;
  int m_last;
  int m_sel;
  int m_held;
  bit m_to;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.p_sel_width(SELW), .p_timeout(TMO)) dut (
    .i_w_clk    (clk),
    .i_w_rst_n  (rst_n),
    .i_w_req    (req),
    .i_w_done   (done),
    .o_w_grant  (grant),
    .o_w_sel    (sel),
    .o_w_valid  (valid),
    .o_w_timeout(timeout)
  );

  assign mux_out = din[sel];

  function automatic int pick(input logic [NREQ-1:0] rq, input int base, input int skip);
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (base + off) % NREQ;
      if (rq[idx] && idx != skip) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_owner = -1; m_last = NREQ - 1; m_sel = 0; m_held = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        int w;
        w = pick(req, m_last, -1);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_held = 1;
        end
      end else begin
        bit normal, forced;
        normal = done || !req[m_owner];
        forced = TO_EN && (m_held >= TMO);
        if (normal || forced) begin
          int w;
          m_to   = forced && !normal;
          m_last = m_owner;
          w = pick(req, m_owner, m_owner);
          m_owner = w;
          if (w >= 0) begin
            m_sel = w; m_held = 1;
          end
        end else begin
          m_held++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r_n, input logic [NREQ-1:0] rq, input logic d);
    logic [31:0] exp_grant;
    rst_n = r_n; req = rq; done = d;
    @(posedge clk);
    model_step();
    #1;
    exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk("grant",   32'(grant),   exp_grant);
    chk("sel",     32'(sel),     32'(m_sel));
    chk("valid",   32'(valid),   32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) din[i] = NREQ'(1) << i;
    rst_n = 1'b0; req = '0; done = 1'b0;

    // Reset and idle requests
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0000, 1'b0);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_sel",   32'(sel),   32'd0);
    end

    // All requesting, done every 3rd cycle: 0,1,2,3,0 gapless
    do_reset();
    step(1'b1, 4'b1111, 1'b0);
    chk("rr_first", 32'(sel), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 4'b1111, 1'b0);
      step(1'b1, 4'b1111, 1'b0);
      step(1'b1, 4'b1111, 1'b1);
      chk("rr_sel",   32'(sel),   32'(k % NREQ));
      chk("rr_grant", 32'(grant), 32'd1 << (k % NREQ));
      chk("rr_gap",   32'(valid), 32'd1);
    end

    // Lone requester re-grant after one idle cycle
    do_reset();
    step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 1'b1);
    chk("solo_idle", 32'(valid), 32'd0);
    chk("solo_hold_sel", 32'(sel), 32'd2);
    step(1'b1, 4'b0100, 1'b0);
    chk("solo_regrant", 32'(sel), 32'd2);
    chk("mux_out", 32'(mux_out), 32'h4);

    // Withdrawn request hands over without done
    do_reset();
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    chk("withdraw_sel", 32'(sel), 32'd3);

    // Reset mid-hold
    do_reset();
    step(1'b1, 4'b1000, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_sel",   32'(sel),   32'd0);
    step(1'b1, 4'b1010, 1'b0);
    chk("postrst_sel", 32'(sel), 32'd1);

    // Owner 0 never finishes while requester 1 waits
    do_reset();
    step(1'b1, 4'b0011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0011, 1'b0);
      chk("to_hold_sel", 32'(sel), 32'd0);
    end
    step(1'b1, 4'b0011, 1'b0);
`ifdef ARB_TIMEOUT_EN
    chk("to_sel",   32'(sel),     32'd1);
    chk("to_pulse", 32'(timeout), 32'd1);
`else
    chk("to_sel",   32'(sel),     32'd0);
    chk("to_pulse", 32'(timeout), 32'd0);
`endif
    step(1'b1, 4'b0011, 1'b0);
    chk("to_pulse_end", 32'(timeout), 32'd0);

    // Random traffic with mostly-stable requests
    do_reset();
    begin
      logic [NREQ-1:0] rq;
      rq = '0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) rq = NREQ'($urandom_range(0, 15));
        step(($urandom_range(0, 59) != 0), rq, ($urandom_range(0, 4) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one `mux` datapath (2**p_sel_width data inputs, one output) among 2**p_sel_width requesters. It drives the mux select and a one-hot grant vector, and holds the grant for one owner until that owner releases. It sits directly in front of the mux select input, so each requester sees exclusive ownership of the shared output for a multi-cycle transfer.

## Interface
- p_sel_width, 2: select width; N = 2**p_sel_width requesters.
- p_timeout, 16: maximum hold cycles before a forced release (used only with ARB_TIMEOUT_EN); legal range ≥ 2.
- i_w_clk  input  1  clock; all logic on the rising edge.
- i_w_rst_n  input  1  reset, synchronous, active-low.
- i_w_req  input  N  request vector; bit k set means requester k wants the mux.
- i_w_done  input  1  current owner finishes; sampled only while o_w_valid=1.
- o_w_grant  output  N  one-hot grant, registered; all zeros when no owner.
- o_w_sel  output  p_sel_width  mux select, registered; equals the index of the current owner.
- o_w_valid  output  1  an owner holds the mux.
- o_w_timeout  output  1  one-cycle pulse on a forced release.

## Operation
- State machine with two states, IDLE and HOLD. Internal register `last` holds the index of the most recent owner.
- Reset (i_w_rst_n=0 at a clock edge):
  - State goes to IDLE.
  - o_w_grant=0, o_w_sel=0, o_w_valid=0, o_w_timeout=0.
  - `last` = N-1, so requester 0 has first priority after reset.
  - Timeout counter = 0.
  - Reset overrides every other input, including a reset that arrives mid-HOLD.
- Arbitration picks the winner as the first set bit of i_w_req, searching from index last+1 upward and wrapping modulo N. This is a purely combinational search.
- IDLE:
  - If i_w_req≠0, the next state is HOLD with the winner granted: o_w_grant=1<<w, o_w_sel=w, o_w_valid=1.
  - Otherwise stay in IDLE with outputs unchanged. o_w_sel keeps its last value.
- HOLD with owner k: the owner releases when i_w_done=1, or when i_w_req[k]=0 (request withdrawn), or on a forced timeout.
- On release:
  - `last` = k.
  - Arbitration runs in the same cycle over i_w_req with bit k masked, so the releasing owner cannot win back-to-back.
  - If any other request is set, the next state is HOLD with the new owner, giving a gapless handover.
  - Otherwise the next state is IDLE with o_w_grant=0 and o_w_valid=0.
- A single requester that releases and still requests regains the grant after exactly one IDLE cycle.
- Requests from non-owners during HOLD are ignored until the release.
- i_w_done while in IDLE is ignored.

## Timing
- Request to grant latency is 1 cycle: i_w_req is sampled at edge t, and o_w_grant, o_w_sel and o_w_valid are valid after edge t.
- Release to next grant is 1 cycle when another requester is waiting.
- All outputs are registered; there are no combinational paths from input to output.
- o_w_sel and o_w_grant always change on the same edge and are always consistent while o_w_valid=1.
- Simultaneous i_w_done and a timeout in the same cycle count as a normal release, so o_w_timeout stays 0.

## Configuration
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on every new grant and increments each cycle in HOLD.
  - When the owner has held for p_timeout cycles without releasing, it is force-released on the next edge, using the same handover rules as a normal release.
  - o_w_timeout=1 for exactly that cycle.
- When not defined:
  - No counter is built.
  - o_w_timeout is tied to 0.
  - An owner holds the mux indefinitely.

## Test plan
- Reset, then i_w_req=4'b0000 for 5 cycles: o_w_valid=0, o_w_grant=0, o_w_sel=0 throughout.
- i_w_req=4'b1111 held, i_w_done pulsed one cycle every 3 cycles: o_w_sel sequence 0,1,2,3,0 with gapless handovers; o_w_grant tracks 0001, 0010, 0100, 1000.
- Owner 2 granted, then i_w_req=4'b0100 with a done pulse: 1 IDLE cycle, then o_w_sel=2 again; the mux output equals i_w_in[2] when driven with i_w_in=1<<2.
- Owner 1 granted, i_w_req[1] dropped without done, i_w_req[3]=1: the next cycle gives o_w_sel=3.
- Reset asserted mid-HOLD (owner 3): after the edge, all outputs are 0; the first grant after reset goes to the lowest requesting index.
- With ARB_TIMEOUT_EN and p_timeout=4: owner 0 never asserts done and requester 1 is waiting. Owner 0 holds for 4 cycles, then o_w_timeout=1 for one cycle and o_w_sel=1. Without the macro, o_w_sel stays 0.
